result_display_seq: RTL and testbench

RESULT_DISPLAY_SEQ -- requirements
Module: result_display_seq

---
 rtl/result_display_pkg.sv | 11 +
 rtl/dwell_timer.sv | 34 +++
 rtl/result_display_seq.sv | 122 ++++++++++++
 tb/tb_result_display_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_display_pkg.sv
// Shared types for the result display sequencer.
// Holds the two-state FSM encoding used by result_display_seq.
// No ports; imported by the top module.
package result_display_pkg;

  typedef enum logic {
    FILL    = 1'b0,
    DISPLAY = 1'b1
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Dwell timer: counts enabled cycles and flags the last cycle of a dwell period.
// Ports: clk_i/reset_i (async active-high), clear_i forces count to 0 (wins over en_i),
//        en_i counts one cycle, expire_o high during the final enabled cycle of the period.
module dwell_timer #(
  parameter int cycles_p = 60000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (cycles_p > 1) ? $clog2(cycles_p) : 1;
  localparam logic [CW-1:0] LAST = CW'(cycles_p - 1);

  logic [CW-1:0] r_cnt;

  // Expiry is independent of clear_i so an advance landing on the final
  // cycle is seen as a single step by the parent, not two.
  assign expire_o = en_i && (r_cnt == LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/result_display_seq.sv
// Result display sequencer: captures depth_p elements, then shows each for
// dwell_cycles_p cycles (advance_i skips ahead, flush_i aborts the frame).
// Ports: clk_i/reset_i (async active-high); valid_i/data_i/ready_o fill side;
//        flush_i, advance_i controls; data_o/index_o/count_o/display_o/done_o status.
// Build option: RESULT_DISPLAY_REPLAY_EN loops the frame forever instead of
// returning to FILL after the last element.
module result_display_seq
  import result_display_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int depth_p        = 4,
  parameter int dwell_cycles_p = 60000000
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  input  logic                         flush_i,
  input  logic                         advance_i,
  output logic [width_p-1:0]           data_o,
  output logic [$clog2(depth_p)-1:0]   index_o,
  output logic [$clog2(depth_p+1)-1:0] count_o,
  output logic                         display_o,
  output logic                         done_o
);

  localparam int IDX_W = $clog2(depth_p);
  localparam int CNT_W = $clog2(depth_p + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(depth_p - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(depth_p - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth_p);

  state_t             r_state;
  logic [IDX_W-1:0]   r_index;
  logic [CNT_W-1:0]   r_count;
  logic               r_done;
  logic [width_p-1:0] r_buf [depth_p];

  logic w_display;
  logic w_fill_wr;
  logic w_expire;
  logic w_step;
  logic w_clear;

  assign w_display = (r_state == DISPLAY);
  // flush_i suppresses the write so an aborted element never lands in the buffer.
  assign w_fill_wr = !w_display && valid_i && !flush_i;
  assign w_step    = w_display && (advance_i || w_expire);
  // Hold the timer at zero outside DISPLAY so every frame starts a fresh dwell.
  assign w_clear   = flush_i || !w_display || advance_i;

  dwell_timer #(
    .cycles_p (dwell_cycles_p)
  ) u_dwell (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (w_clear),
    .en_i     (w_display),
    .expire_o (w_expire)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= FILL;
      r_index <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush_i) begin
        r_state <= FILL;
        r_index <= '0;
        r_count <= '0;
      end else begin
        case (r_state)
          FILL: begin
            if (valid_i) begin
              if (r_count == LAST_CNT) begin
                r_state <= DISPLAY;
                r_index <= '0;
                r_count <= FULL_CNT;
              end else begin
                r_count <= r_count + CNT_W'(1);
              end
            end
          end
          DISPLAY: begin
            if (w_step) begin
              if (r_index == LAST_IDX) begin
                r_done  <= 1'b1;
                r_index <= '0;
`ifdef RESULT_DISPLAY_REPLAY_EN
                r_state <= DISPLAY;
`else
                r_state <= FILL;
                r_count <= '0;
`endif
              end else begin
                r_index <= r_index + IDX_W'(1);
              end
            end
          end
          default: r_state <= FILL;
        endcase
      end
    end
  end

  // Buffer is never cleared; count_o alone says which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_fill_wr) r_buf[r_count[IDX_W-1:0]] <= data_i;
  end

  assign ready_o   = !w_display;
  assign display_o = w_display;
  assign data_o    = w_display ? r_buf[r_index] : '0;
  assign index_o   = r_index;
  assign count_o   = r_count;
  assign done_o    = r_done;

endmodule

// File: tb/tb_result_display_seq.sv
module tb_result_display_seq;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int DWELL = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] din;
  logic       rdy;
  logic       flush;
  logic       adv;
  logic [7:0] dout;
  logic [1:0] idx;
  logic [2:0] cnt;
  logic       disp;
  logic       done;

  result_display_seq #(
    .width_p        (W),
    .depth_p        (DEPTH),
    .dwell_cycles_p (DWELL)
  ) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .valid_i   (valid),
    .data_i    (din),
    .ready_o   (rdy),
    .flush_i   (flush),
    .advance_i (adv),
    .data_o    (dout),
    .index_o   (idx),
    .count_o   (cnt),
    .display_o (disp),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       disp;
    logic       done;
    logic [7:0] data;
    logic [1:0] idx;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: the frame is a queue of captured elements; while showing,
  // m_pos is the element on screen and m_shown how many cycles it has been up.
  logic [7:0] m_frame[$];
  bit         m_showing = 0;
  int         m_pos     = 0;
  int         m_shown   = 0;
  bit         m_done    = 0;

  task automatic model_step(input logic v, input logic [7:0] d, input logic a,
                            input logic f, input logic r);
    m_done = 0;
    if (r || f) begin
      m_showing = 0;
      m_frame.delete();
      m_pos   = 0;
      m_shown = 0;
    end else if (!m_showing) begin
      if (v) begin
        m_frame.push_back(d);
        if (m_frame.size() == DEPTH) begin
          m_showing = 1;
          m_pos     = 0;
          m_shown   = 0;
        end
      end
    end else begin
      if (a || (m_shown + 1 == DWELL)) begin
        m_shown = 0;
        if (m_pos == DEPTH - 1) begin
          m_done = 1;
          m_pos  = 0;
`ifndef RESULT_DISPLAY_REPLAY_EN
          m_showing = 0;
          m_frame.delete();
`endif
        end else begin
          m_pos = m_pos + 1;
        end
      end else begin
        m_shown = m_shown + 1;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rdy  = !m_showing;
    e.disp = m_showing;
    e.done = m_done;
    e.data = m_showing ? m_frame[m_pos] : 8'h00;
    e.idx  = 2'(m_pos);
    e.cnt  = 3'(m_frame.size());
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // One clock of stimulus: inputs change on the falling edge, the model predicts
  // the state after the next rising edge, and the scoreboard holds that prediction.
  task automatic cycle(input logic v, input logic [7:0] d, input logic a,
                       input logic f, input logic r);
    @(negedge clk);
    valid = v; din = d; adv = a; flush = f; rst = r;
    model_step(v, d, a, f, r);
    sb_q.push_back(model_out());
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_frame(input logic [7:0] b);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(b + 8'(i) * 8'h11), 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle with a pending prediction, compare the whole output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_total++;
        if (rdy === e.rdy && disp === e.disp && done === e.done &&
            dout === e.data && idx === e.idx && cnt === e.cnt) begin
          n_pass++;
        end else begin
          $display("FAIL outputs @%0t: got rdy=%b disp=%b done=%b data=%h idx=%0d cnt=%0d expected rdy=%b disp=%b done=%b data=%h idx=%0d cnt=%0d",
                   $time, rdy, disp, done, dout, idx, cnt,
                   e.rdy, e.disp, e.done, e.data, e.idx, e.cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; valid = 1'b0; din = 8'h00; adv = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready",   32'(rdy),  32'd1);
    check("reset_display", 32'(disp), 32'd0);
    check("reset_done",    32'(done), 32'd0);
    check("reset_count",   32'(cnt),  32'd0);
    check("reset_index",   32'(idx),  32'd0);
    check("reset_data",    32'(dout), 32'd0);

    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Basic frame 0x11..0x44 shown to completion and back to FILL.
    write_frame(8'h11);
    idle(DEPTH * DWELL + 4);

    // Flush with a coincident write after two elements.
    cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    idle(1);
    write_frame(8'h05);
    // Advance during dwell cycle 1, then advance on the expiry cycle.
    idle(1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(DWELL - 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(DEPTH * DWELL);
    // Flush mid-display.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Reset while index 2 is on screen: outputs must drop immediately.
    write_frame(8'h20);
    for (int k = 0; k < 50 && !(m_showing && m_pos == 2); k++) idle(1);
    check("reach_index2", 32'(m_showing && m_pos == 2), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_ready",   32'(rdy),  32'd1);
    check("async_rst_display", 32'(disp), 32'd0);
    check("async_rst_done",    32'(done), 32'd0);
    check("async_rst_count",   32'(cnt),  32'd0);
    check("async_rst_index",   32'(idx),  32'd0);
    check("async_rst_data",    32'(dout), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 9) < 6), 8'($urandom),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 99) < 2), 1'b0);
    end
    // Long idle so a replay build shows several loops and done pulses.
    write_frame(8'h11);
    idle(2 * DEPTH * DWELL + 3);

    @(posedge clk);
    #4;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
